// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: states,
// instruction classes, datapath select codes and opcode values.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_PC4,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_ECALL,
        C_ILLEGAL
    } inst_class_t;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_ALU    = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/opcode_class_decoder.sv
// Maps the IR opcode field onto an instruction class; shared by the
// sequencer and the immediate-format logic.
module opcode_class_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output inst_class_t inst_class
);

    always_comb begin
        inst_class = C_ILLEGAL;
        case (opcode)
            OP_ARITH:     inst_class = C_R;
            OP_ARITH_IMM: inst_class = C_I;
            OP_LOAD:      inst_class = C_LOAD;
            OP_STORE:     inst_class = C_STORE;
            OP_BRANCH:    inst_class = C_BRANCH;
            OP_JAL:       inst_class = C_JAL;
            OP_JALR:      inst_class = C_JALR;
            OP_SYSTEM:    inst_class = C_ECALL;
            default:      inst_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: steers ALU, memory port and IR/MDR/ALUOut
// enables one instruction at a time; halts on ECALL or an unknown opcode.
// state  | meaning
// S_IF   | fetch, hold request until mem_ready, load IR
// S_ID   | decode, ALUOut <= PC+imm
// S_EX   | execute by class; branch/JAL resolve here
// S_MEM  | data access at ALUOut
// S_WB   | rd write and PC update
// S_PC4  | PC <= PC+4 for not-taken branch / non-halting ECALL
// S_HALT | absorbing stop
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       mem_ready,
    input  logic       ecall_halt,
    output logic       pc_write,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_halted,
    output logic       illegal_inst
);

    state_t      r_state;
    state_t      w_next;
    inst_class_t w_class;
    logic        r_is_halted;
    logic        r_illegal;
    logic        w_set_illegal;

    opcode_class_decoder u_dec (
        .opcode     (opcode),
        .inst_class (w_class)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IF;
            r_is_halted <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT)
                r_is_halted <= 1'b1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        pc_write      = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;

        case (r_state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = S_ID;
                end
            end
            S_ID: begin
                alu_src_b = SRCB_IMM;
                case (w_class)
                    C_ECALL:   w_next = ecall_halt ? S_HALT : S_PC4;
                    C_ILLEGAL: begin
                        w_set_illegal = 1'b1;
                        w_next        = S_HALT;
                    end
                    default:   w_next = S_EX;
                endcase
            end
            S_EX: begin
                alu_src_a = 1'b1;
                case (w_class)
                    C_R: begin
                        alu_op = ALUOP_FUNCT;
                        w_next = S_WB;
                    end
                    C_I: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALUOP_FUNCT;
                        w_next    = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_b = SRCB_IMM;
                        w_next    = S_MEM;
                    end
                    C_JALR: begin
                        alu_src_b = SRCB_IMM;
                        w_next    = S_WB;
                    end
                    C_BRANCH: begin
                        alu_op = ALUOP_BRANCH;
                        if (bcond) begin
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                            w_next    = S_IF;
                        end else begin
                            w_next = S_PC4;
                        end
                    end
                    C_JAL: begin
                        // rd <= PC+4 from the live ALU while PC loads the ALUOut target
                        alu_src_a = 1'b0;
                        alu_src_b = SRCB_FOUR;
                        reg_write = 1'b1;
                        wb_sel    = WB_ALU;
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                        w_next    = S_IF;
                    end
                    default: w_next = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (w_class == C_LOAD);
                mem_write = (w_class == C_STORE);
                if (mem_ready) begin
                    if (w_class == C_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        alu_src_b = SRCB_FOUR;
                        pc_write  = (w_class == C_STORE);
                        w_next    = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                case (w_class)
                    C_LOAD: wb_sel = WB_MDR;
                    C_JALR: begin
                        wb_sel    = WB_ALU;
                        pc_source = 1'b1;
                    end
                    default: wb_sel = WB_ALUOUT;
                endcase
                w_next = S_IF;
            end
            S_PC4: begin
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                w_next    = S_IF;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase

        if (!reset_n) begin
            pc_write  = 1'b0;
            pc_source = 1'b0;
            i_or_d    = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            wb_sel    = WB_ALUOUT;
            alu_src_a = 1'b0;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_ADD;
        end
    end

    assign is_halted    = r_is_halted;
    assign illegal_inst = r_illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: instruction programs feed an IR
// and memory responder; a monitor compares per-instruction behaviour to a model.
module tb_multicycle_control_fsm;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_ECALL  = 7'b1110011;

    typedef struct {
        logic [6:0] op;
        bit         bc;
        bit         hlt;
        int         lf;
        int         lm;
    } instr_t;

    typedef struct {
        int cycles;
        int regw;
        int wbsel;
        int regw_cyc;
        int pcw;
        int pcsrc;
        int irw;
        int mrd;
        int mwr;
        int iord;
        int halts;
        int illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode;
    logic       bcond, mem_ready, ecall_halt;
    logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] wb_sel, alu_src_b, alu_op;
    logic       alu_src_a, is_halted, illegal_inst;
    logic [15:0] outs;

    int checks = 0;
    int errors = 0;

    instr_t op_q[$];
    int     lat_q[$];
    exp_t   exp_q[$];

    bit mon_en = 0;
    bit episode_done;
    int cyc, n_regw, wbsel_seen, regw_cyc_seen, n_pcw, pcsrc_seen, n_irw, n_mrd, n_mwr, n_iord;
    int halt_act, halt_drop, halt_cycles, inst_idx;

    always #5 clk = ~clk;

    assign outs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                   wb_sel, alu_src_a, alu_src_b, alu_op, is_halted, illegal_inst};

    multicycle_control_fsm dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .bcond        (bcond),
        .mem_ready    (mem_ready),
        .ecall_halt   (ecall_halt),
        .pc_write     (pc_write),
        .pc_source    (pc_source),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .is_halted    (is_halted),
        .illegal_inst (illegal_inst)
    );

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input bit bc, input bit hlt,
                                  input int lf, input int lm);
        instr_t t;
        t.op = op; t.bc = bc; t.hlt = hlt; t.lf = lf; t.lm = lm;
        return t;
    endfunction

    // Reference: per-instruction totals derived from the cycle table and class rules
    function automatic exp_t model(input instr_t in);
        exp_t e;
        int   base;
        bit   mem;
        e = '{default: 0};
        mem = (in.op == T_LOAD) || (in.op == T_STORE);
        e.irw = 1;
        e.pcw = 1;
        e.mrd = in.lf + 1;
        base = 0;
        case (in.op)
            T_R, T_I: begin base = 4; e.regw = 1; e.wbsel = 0; end
            T_LOAD:   begin base = 5; e.regw = 1; e.wbsel = 1; e.mrd += in.lm + 1; e.iord = in.lm + 1; end
            T_STORE:  begin base = 4; e.mwr = in.lm + 1; e.iord = in.lm + 1; end
            T_BRANCH: begin base = in.bc ? 3 : 4; e.pcsrc = in.bc ? 1 : 0; end
            T_JAL:    begin base = 3; e.regw = 1; e.wbsel = 2; e.pcsrc = 1; end
            T_JALR:   begin base = 4; e.regw = 1; e.wbsel = 2; e.pcsrc = 1; end
            T_ECALL: begin
                if (in.hlt) begin base = 2; e.halts = 1; e.pcw = 0; end
                else base = 3;
            end
            default: begin base = 2; e.halts = 1; e.illegal = 1; e.pcw = 0; end
        endcase
        e.cycles   = base + in.lf + (mem ? in.lm : 0);
        e.regw_cyc = (e.regw != 0) ? e.cycles : 0;
        return e;
    endfunction

    task automatic clear_acc();
        cyc = 0; n_regw = 0; wbsel_seen = 0; regw_cyc_seen = 0; n_pcw = 0;
        pcsrc_seen = 0; n_irw = 0; n_mrd = 0; n_mwr = 0; n_iord = 0;
    endtask

    // IR model and memory responder; latencies are consumed in request order
    initial begin : driver
        int     cnt;
        bit     active, grant, irw_s;
        instr_t cur;
        cnt = 0; active = 0; grant = 0; irw_s = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                mem_ready = 1'b0; active = 0; grant = 0; irw_s = 0;
            end else begin
                if (irw_s) begin
                    if (op_q.size() > 0) begin
                        cur = op_q.pop_front();
                        opcode = cur.op; bcond = cur.bc; ecall_halt = cur.hlt;
                    end else begin
                        opcode = 7'h7F;
                    end
                end
                if (grant) active = 0;
                grant = 0;
                #1;
                if (mem_read || mem_write) begin
                    if (!active) begin
                        active = 1;
                        cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                    end
                    if (cnt == 0) begin
                        mem_ready = 1'b1; grant = 1;
                    end else begin
                        mem_ready = 1'b0; cnt--;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            irw_s = ir_write && reset_n;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && reset_n) begin
            if (episode_done) begin
                halt_cycles++;
                if (mem_read || mem_write || pc_write || reg_write || ir_write) halt_act++;
                if (!is_halted) halt_drop++;
            end else if (is_halted) begin
                episode_done = 1;
                if (exp_q.size() == 0) begin
                    check("halt_without_expectation", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("halt_expected#%0d", inst_idx), 1, e.halts);
                    check($sformatf("halt_cycles#%0d", inst_idx), cyc, e.cycles);
                    check($sformatf("halt_illegal#%0d", inst_idx), illegal_inst, e.illegal);
                    check($sformatf("halt_pcw#%0d", inst_idx), n_pcw, e.pcw);
                    check($sformatf("halt_regw#%0d", inst_idx), n_regw, e.regw);
                    check($sformatf("halt_mrd#%0d", inst_idx), n_mrd, e.mrd);
                    check($sformatf("halt_irw#%0d", inst_idx), n_irw, e.irw);
                end
            end else begin
                cyc++;
                if (reg_write) begin n_regw++; wbsel_seen = wb_sel; regw_cyc_seen = cyc; end
                if (pc_write)  begin n_pcw++; pcsrc_seen = pc_source; end
                if (ir_write)  n_irw++;
                if (mem_read)  n_mrd++;
                if (mem_write) n_mwr++;
                if (i_or_d)    n_iord++;
                if (pc_write) begin
                    if (exp_q.size() == 0) begin
                        check("retire_without_expectation", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("halts#%0d", inst_idx), 0, e.halts);
                        check($sformatf("cycles#%0d", inst_idx), cyc, e.cycles);
                        check($sformatf("reg_write_count#%0d", inst_idx), n_regw, e.regw);
                        if (e.regw != 0) begin
                            check($sformatf("wb_sel#%0d", inst_idx), wbsel_seen, e.wbsel);
                            check($sformatf("reg_write_cycle#%0d", inst_idx), regw_cyc_seen, e.regw_cyc);
                        end
                        check($sformatf("pc_write_count#%0d", inst_idx), n_pcw, e.pcw);
                        check($sformatf("pc_source#%0d", inst_idx), pcsrc_seen, e.pcsrc);
                        check($sformatf("ir_write_count#%0d", inst_idx), n_irw, e.irw);
                        check($sformatf("mem_read_cycles#%0d", inst_idx), n_mrd, e.mrd);
                        check($sformatf("mem_write_cycles#%0d", inst_idx), n_mwr, e.mwr);
                        check($sformatf("i_or_d_cycles#%0d", inst_idx), n_iord, e.iord);
                    end
                    inst_idx++;
                    clear_acc();
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 0;
        reset_n = 1'b0;
        op_q.delete(); lat_q.delete(); exp_q.delete();
        #1;
        check("reset_outputs_async", outs, 0);
        repeat (2) @(negedge clk);
        check("reset_outputs_held", outs, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic run_episode(input instr_t prog[$]);
        do_reset();
        foreach (prog[k]) begin
            op_q.push_back(prog[k]);
            lat_q.push_back(prog[k].lf);
            if (prog[k].op == T_LOAD || prog[k].op == T_STORE) lat_q.push_back(prog[k].lm);
            exp_q.push_back(model(prog[k]));
        end
        clear_acc();
        episode_done = 0; halt_act = 0; halt_drop = 0; halt_cycles = 0; inst_idx = 0;
        mon_en = 1;
        release_reset();
        for (int i = 0; i < 4000 && !episode_done; i++) @(negedge clk);
        check("episode_reached_halt", episode_done, 1);
        if (episode_done) begin
            repeat (21) @(negedge clk);
            check("halt_no_activity", halt_act, 0);
            check("halt_sticky", halt_drop, 0);
            check("halt_observed_cycles_ge20", halt_cycles >= 20, 1);
            check("is_halted_end", is_halted, 1);
            check("expectations_left", exp_q.size(), 0);
        end
    endtask

    initial begin : main
        instr_t     prog[$];
        logic [6:0] ops[8];
        logic [6:0] bad[3];
        logic [6:0] op;
        bit         found;
        int         n;

        ops = '{T_R, T_I, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_ECALL};
        bad = '{7'h7F, 7'h00, 7'h6B};
        reset_n = 1'b0; opcode = 7'h00; bcond = 1'b0; mem_ready = 1'b0; ecall_halt = 1'b0;

        prog.delete();
        prog.push_back(mk(T_R,      0, 0, 0, 0));
        prog.push_back(mk(T_LOAD,   0, 0, 0, 3));
        prog.push_back(mk(T_BRANCH, 1, 0, 0, 0));
        prog.push_back(mk(T_BRANCH, 0, 0, 0, 0));
        prog.push_back(mk(T_JAL,    0, 0, 0, 0));
        prog.push_back(mk(T_JALR,   0, 0, 0, 0));
        prog.push_back(mk(T_ECALL,  0, 0, 0, 0));
        prog.push_back(mk(T_STORE,  0, 0, 1, 2));
        prog.push_back(mk(T_I,      0, 0, 2, 0));
        prog.push_back(mk(7'h7F,    0, 0, 0, 0));
        run_episode(prog);

        prog.delete();
        prog.push_back(mk(T_R,     0, 0, 1, 0));
        prog.push_back(mk(T_ECALL, 0, 1, 2, 0));
        run_episode(prog);

        // Reset while a data access is stalled
        do_reset();
        op_q.push_back(mk(T_LOAD, 0, 0, 0, 10));
        lat_q.push_back(0);
        lat_q.push_back(10);
        release_reset();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_read && i_or_d) found = 1;
        end
        check("rst_mid_reached_mem", found, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_outputs_zero", outs, 0);
        repeat (2) @(negedge clk);
        op_q.delete(); lat_q.delete();
        release_reset();
        #1;
        check("rst_release_mem_read", mem_read, 1);
        check("rst_release_i_or_d", i_or_d, 0);
        check("rst_release_is_halted", is_halted, 0);
        check("rst_release_illegal", illegal_inst, 0);

        for (int ep = 0; ep < 4; ep++) begin
            prog.delete();
            n = $urandom_range(8, 15);
            for (int k = 0; k < n; k++) begin
                op = ops[$urandom_range(0, 7)];
                prog.push_back(mk(op, 1'($urandom_range(0, 1)), 0,
                                  $urandom_range(0, 3), $urandom_range(0, 3)));
            end
            if ($urandom_range(0, 1) == 1)
                prog.push_back(mk(T_ECALL, 0, 1, $urandom_range(0, 3), 0));
            else
                prog.push_back(mk(bad[$urandom_range(0, 2)], 0, 0, $urandom_range(0, 3), 0));
            run_episode(prog);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
